// File: rtl/risc16_system.sv
// risc16_system: single-cycle RiSC-16 processor with on-chip instruction
// memory, data memory and an 8x16 register file.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (PC and registers only)
//   pen    in   program enable: writes instr to imem[addr], holds execution
//   addr   in   imem word address for program load (low bits used)
//   instr  in   instruction word to load
//
// Probe-visible internals: PC (program counter), IR (imem[PC]),
// rf.dataRegister[0..7].

// Register file: r0 always reads zero and ignores writes.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   we_i, waddr_i, wdata_i   write port
//   raddr_a_i, raddr_b_i     read addresses
//   rdata_a_c_o, rdata_b_c_o combinational read data
module risc16_regfile #(
    parameter int unsigned WORD_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we_i,
    input  logic [2:0]             waddr_i,
    input  logic [WORD_LENGTH-1:0] wdata_i,
    input  logic [2:0]             raddr_a_i,
    input  logic [2:0]             raddr_b_i,
    output logic [WORD_LENGTH-1:0] rdata_a_c_o,
    output logic [WORD_LENGTH-1:0] rdata_b_c_o
);
    localparam int unsigned NUM_REGS = 8;

    logic [WORD_LENGTH-1:0] dataRegister [NUM_REGS];

    // Register writes; r0 is never written so it stays at its reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                dataRegister[i] <= '0;
            end
        end else if (we_i && (waddr_i != 3'd0)) begin
            dataRegister[waddr_i] <= wdata_i;
        end
    end

    // r0 decoded explicitly so it reads zero even before the first reset.
    assign rdata_a_c_o = (raddr_a_i == 3'd0) ? '0 : dataRegister[raddr_a_i];
    assign rdata_b_c_o = (raddr_b_i == 3'd0) ? '0 : dataRegister[raddr_b_i];
endmodule

module risc16_system #(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned IMEM_WORDS  = 256,
    parameter int unsigned DMEM_WORDS  = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pen,
    input  logic [WORD_LENGTH-1:0] addr,
    input  logic [WORD_LENGTH-1:0] instr
);
    localparam int unsigned IMEM_AW = $clog2(IMEM_WORDS);
    localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    logic [WORD_LENGTH-1:0] imem_q [IMEM_WORDS];
    logic [WORD_LENGTH-1:0] dmem_q [DMEM_WORDS];

    logic [WORD_LENGTH-1:0] PC;
    logic [WORD_LENGTH-1:0] pc_d;
    logic [WORD_LENGTH-1:0] IR;

    logic [2:0]             op;
    logic [2:0]             ra_idx;
    logic [2:0]             rb_idx;
    logic [2:0]             rc_idx;
    logic [WORD_LENGTH-1:0] simm;
    logic [9:0]             imm10;

    logic [2:0]             rport_b_idx;
    logic [WORD_LENGTH-1:0] rb_val;
    logic [WORD_LENGTH-1:0] rport_b_val;
    logic [WORD_LENGTH-1:0] eff_addr;
    logic [WORD_LENGTH-1:0] pc_plus1;
    logic [WORD_LENGTH-1:0] dmem_rdata;

    logic                   exec_en;
    logic                   rf_we_c;
    logic [WORD_LENGTH-1:0] rf_wdata;
    logic                   dmem_we_c;
    logic                   unused_c;

    // Fetch and field decode.
    assign IR     = imem_q[PC[IMEM_AW-1:0]];
    assign op     = IR[15:13];
    assign ra_idx = IR[12:10];
    assign rb_idx = IR[9:7];
    assign rc_idx = IR[2:0];
    assign simm   = {{(WORD_LENGTH-7){IR[6]}}, IR[6:0]};
    assign imm10  = IR[9:0];

    assign exec_en = !pen && !rst;

    // Port A always reads rB; port B reads rC for ALU ops, otherwise rA
    // (store data and beq compare).
    assign rport_b_idx = ((op == OP_ADD) || (op == OP_NAND)) ? rc_idx : ra_idx;

    risc16_regfile #(
        .WORD_LENGTH(WORD_LENGTH)
    ) rf (
        .clk        (clk),
        .rst        (rst),
        .we_i       (exec_en && rf_we_c),
        .waddr_i    (ra_idx),
        .wdata_i    (rf_wdata),
        .raddr_a_i  (rb_idx),
        .raddr_b_i  (rport_b_idx),
        .rdata_a_c_o(rb_val),
        .rdata_b_c_o(rport_b_val)
    );

    assign eff_addr   = rb_val + simm;
    assign pc_plus1   = PC + WORD_LENGTH'(1);
    assign dmem_rdata = dmem_q[eff_addr[DMEM_AW-1:0]];

    // Execute: next PC, register write-back and store enable.
    always_comb begin
        pc_d      = pc_plus1;
        rf_we_c   = 1'b0;
        rf_wdata  = '0;
        dmem_we_c = 1'b0;
        unique case (op)
            OP_ADD: begin
                rf_we_c  = 1'b1;
                rf_wdata = rb_val + rport_b_val;
            end
            OP_ADDI: begin
                rf_we_c  = 1'b1;
                rf_wdata = eff_addr;
            end
            OP_NAND: begin
                rf_we_c  = 1'b1;
                rf_wdata = ~(rb_val & rport_b_val);
            end
            OP_LUI: begin
                rf_we_c  = 1'b1;
                rf_wdata = {imm10, 6'b0};
            end
            OP_SW: begin
                dmem_we_c = 1'b1;
            end
            OP_LW: begin
                rf_we_c  = 1'b1;
                rf_wdata = dmem_rdata;
            end
            OP_BEQ: begin
                if (rport_b_val == rb_val) begin
                    pc_d = pc_plus1 + simm;
                end
            end
            OP_JALR: begin
                // rB was read combinationally, so writing rA cannot disturb it.
                rf_we_c  = 1'b1;
                rf_wdata = pc_plus1;
                pc_d     = rb_val;
            end
            default: begin
            end
        endcase
    end

    // Program counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            PC <= '0;
        end else if (exec_en) begin
            PC <= pc_d;
        end
    end

    // Program load is independent of reset so a loaded image survives it.
    always_ff @(posedge clk) begin
        if (pen) begin
            imem_q[addr[IMEM_AW-1:0]] <= instr;
        end
    end

    // Data memory store.
    always_ff @(posedge clk) begin
        if (exec_en && dmem_we_c) begin
            dmem_q[eff_addr[DMEM_AW-1:0]] <= rport_b_val;
        end
    end

    // Address bits above the memory depths are intentionally ignored.
    assign unused_c = ^{addr[WORD_LENGTH-1:IMEM_AW], PC[WORD_LENGTH-1:IMEM_AW],
                        eff_addr[WORD_LENGTH-1:DMEM_AW]};
endmodule

// File: tb/tb_risc16_system.sv
module tb_risc16_system;
    logic        clk;
    logic        rst;
    logic        pen;
    logic [15:0] addr;
    logic [15:0] instr;

    int tests_run;
    int tests_failed;

    risc16_system dut (
        .clk  (clk),
        .rst  (rst),
        .pen  (pen),
        .addr (addr),
        .instr(instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        instr = d;
        tick();
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        pen   = 1'b1;
        rst   = 1'b0;
        addr  = '0;
        instr = '0;

        // Program 1: lui r2,0x200; lui r3,0x100; add r2,r2,r3
        load(16'h0000, 16'h6A00);
        load(16'h0001, 16'h6D00);
        load(16'h0002, 16'h0903);

        pen = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_pc", dut.PC, 16'h0000);
        check("rst_ir", dut.IR, 16'h6A00);
        check("rst_r2", dut.rf.dataRegister[2], 16'h0000);
        rst = 1'b0;
        tick();
        check("p1_e1_r2", dut.rf.dataRegister[2], 16'h8000);
        check("p1_e1_pc", dut.PC, 16'h0001);
        tick();
        check("p1_e2_r3", dut.rf.dataRegister[3], 16'h4000);
        check("p1_e2_pc", dut.PC, 16'h0002);
        tick();
        check("p1_e3_r2", dut.rf.dataRegister[2], 16'hC000);
        check("p1_e3_pc", dut.PC, 16'h0003);

        // Load while running: state holds, IR shows the new word at PC.
        pen = 1'b1;
        load(16'h0003, 16'h8403);
        check("hold_pc", dut.PC, 16'h0003);
        check("hold_r2", dut.rf.dataRegister[2], 16'hC000);
        check("hold_r3", dut.rf.dataRegister[3], 16'h4000);
        check("hold_ir", dut.IR, 16'h8403);
        tick();
        check("hold2_pc", dut.PC, 16'h0003);

        // Reset mid-program; program survives and re-runs.
        pen = 1'b0;
        rst = 1'b1;
        tick();
        check("rst2_pc", dut.PC, 16'h0000);
        check("rst2_r2", dut.rf.dataRegister[2], 16'h0000);
        check("rst2_r3", dut.rf.dataRegister[3], 16'h0000);
        check("rst2_ir", dut.IR, 16'h6A00);
        rst = 1'b0;
        tick();
        check("p1b_e1_r2", dut.rf.dataRegister[2], 16'h8000);
        tick();
        check("p1b_e2_r3", dut.rf.dataRegister[3], 16'h4000);
        tick();
        check("p1b_e3_r2", dut.rf.dataRegister[2], 16'hC000);
        check("p1b_e3_pc", dut.PC, 16'h0003);

        // Program 2
        pen = 1'b1;
        load(16'h0001, 16'h247F); // addi r1,r0,-1
        load(16'h0002, 16'h8403); // sw   r1,r0,3
        load(16'h0003, 16'hB003); // lw   r4,r0,3
        load(16'h0004, 16'hFA80); // jalr r6,r5
        load(16'h0010, 16'h2005); // addi r0,r0,5
        load(16'h0011, 16'h5C85); // nand r7,r1,r5
        load(16'h0012, 16'hC683); // beq  r1,r5,3 (not taken)
        load(16'h0013, 16'hC601); // beq  r1,r4,1 (taken)
        load(16'h0015, 16'hC07F); // beq  r0,r0,-1
        // rst and pen together: write to imem[0] and architectural reset.
        rst = 1'b1;
        load(16'h0000, 16'h3410); // addi r5,r0,16
        check("rstpen_pc", dut.PC, 16'h0000);
        check("rstpen_ir", dut.IR, 16'h3410);
        check("rstpen_r2", dut.rf.dataRegister[2], 16'h0000);
        check("rstpen_r3", dut.rf.dataRegister[3], 16'h0000);
        pen = 1'b0;
        rst = 1'b0;

        tick();
        check("addi_r5", dut.rf.dataRegister[5], 16'h0010);
        check("addi_pc", dut.PC, 16'h0001);
        tick();
        check("neg_r1", dut.rf.dataRegister[1], 16'hFFFF);
        tick();
        check("sw_mem", dut.dmem_q[3], 16'hFFFF);
        check("sw_pc", dut.PC, 16'h0003);
        tick();
        check("lw_r4", dut.rf.dataRegister[4], 16'hFFFF);
        check("lw_pc", dut.PC, 16'h0004);
        tick();
        check("jalr_r6", dut.rf.dataRegister[6], 16'h0005);
        check("jalr_pc", dut.PC, 16'h0010);
        check("jalr_r5", dut.rf.dataRegister[5], 16'h0010);
        tick();
        check("r0_write", dut.rf.dataRegister[0], 16'h0000);
        check("r0_pc", dut.PC, 16'h0011);
        tick();
        check("nand_r7", dut.rf.dataRegister[7], 16'hFFEF);
        check("nand_pc", dut.PC, 16'h0012);
        tick();
        check("beq_nt_pc", dut.PC, 16'h0013);
        tick();
        check("beq_t_pc", dut.PC, 16'h0015);
        tick();
        check("beq_loop1_pc", dut.PC, 16'h0015);
        tick();
        check("beq_loop2_pc", dut.PC, 16'h0015);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/risc16_system.md
# risc16_system

Single-cycle RiSC-16 processor with on-chip instruction memory, data memory and an 8×16 register file. A program-load port writes words into instruction memory while execution is held. Every clock edge with execution enabled fetches, executes and retires exactly one instruction. This is the top-level system block used for programming and running small RiSC-16 programs in simulation.

## Interface
- WORD_LENGTH, 16: datapath, register, instruction and address width. Only 16 is supported.
- IMEM_WORDS, 256: instruction memory depth in words.
- DMEM_WORDS, 256: data memory depth in words.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous and active-high.
- pen  in  1  program enable. When 1, load `instr` into instruction memory and hold execution.
- addr  in  16  instruction-memory word address for program load; low log2(IMEM_WORDS) bits used.
- instr  in  16  instruction word to load.
- Probe-visible internals (fixed names):
  - `PC`: 16-bit program counter register.
  - `IR`: 16-bit combinational instruction fetch, imem[PC].
  - `rf.dataRegister[0..7]`: register file, in an instance named `rf`.

## Operation
- Instruction fields:
  - op = [15:13], rA = [12:10], rB = [9:7], rC = [2:0].
  - imm7 = [6:0], signed, sign-extended to 16 bits.
  - imm10 = [9:0].
- Opcodes:
  - 000 add: rA = rB + rC.
  - 001 addi: rA = rB + sext(imm7).
  - 010 nand: rA = ~(rB & rC).
  - 011 lui: rA = {imm10, 6'b0}.
  - 100 sw: dmem[rB + sext(imm7)] = rA.
  - 101 lw: rA = dmem[rB + sext(imm7)].
  - 110 beq: if rA == rB, PC = PC + 1 + sext(imm7).
  - 111 jalr: rA = PC + 1; PC = rB. Read rB before the write to rA.
- All arithmetic is mod 2^16; no flags, no exceptions.
- Non-branch, non-jump instructions set PC = PC + 1, wrapping 0xFFFF → 0x0000.
- r0 reads 0 always; writes to r0 are discarded.
- Memory addresses use the low log2(depth) bits of the effective address, so addresses wrap.
- Program load: on each edge with pen=1, imem[addr] ← instr. This happens regardless of rst.
- Execution is enabled only when pen=0 and rst=0.
- While pen=1:
  - PC, registers and data memory hold.
  - IR continues to reflect imem[PC].
- Reset, on an edge with rst=1:
  - PC ← 0 and r0..r7 ← 0.
  - Instruction and data memory contents are preserved, so a loaded program survives reset.
- rst=1 and pen=1 together: the memory write and the architectural reset both occur.
- Memory contents are undefined until written. No halt instruction; execution continues sequentially.

## Timing
- Reset latency: one edge. After it, PC=0x0000, all registers 0x0000, and IR = imem[0].
- Instruction latency: one cycle. Results, PC update and data-memory store are all visible after the executing edge.
- Data-memory read is combinational within the cycle.
- Program-load write is visible on IR, if PC matches, right after the edge.
- Deasserting pen resumes execution on the next edge from the current PC.
- Asserting rst mid-program resets on the next edge.

## Test plan
- Load and run:
  - Load, with pen=1, addr0=0x6A00 (lui r2,0x200), addr1=0x6D00 (lui r3,0x100), addr2=0x0903 (add r2,r2,r3).
  - Then pen=0, rst=1 for one edge, then rst=0.
  - Required, edge by edge after reset:
    - Reset edge: PC=0, IR=0x6A00.
    - Edge 1: r2=0x8000, PC=1.
    - Edge 2: r3=0x4000, PC=2.
    - Edge 3: r2=0xC000, PC=3.
- Load while running, then reset: PC and registers hold during pen=1. Program memory is intact after rst, and the same results reappear.
- r0 write: `addi r0,r0,5` leaves r0=0 and sets PC+1.
- Memory round trip: `addi r1,r0,-1`, `sw r1,r0,3`, `lw r4,r0,3` → r4=0xFFFF.
- beq: `beq r0,r0,-1` loops, so PC stays constant. With unequal operands, PC advances by 1.
- jalr: with r5=0x0010, `jalr r6,r5` at PC=4 gives r6=0x0005 and PC=0x0010.
